// File: rtl/qspi_pkg.sv
// qspi_pkg: shared device-select and length encodings plus the arbiter state type
package qspi_pkg;
    localparam logic [1:0] SEL_NONE   = 2'd0;
    localparam logic [1:0] SEL_FLASH  = 2'd1;
    localparam logic [1:0] SEL_RAM_A  = 2'd2;
    localparam logic [1:0] SEL_RAM_B  = 2'd3;
    localparam logic [1:0] LEN_1B     = 2'd0;
    localparam logic [1:0] LEN_2B     = 2'd1;
    localparam logic [1:0] LEN_4B     = 2'd2;
    localparam logic [1:0] LEN_STREAM = 2'd3;
    typedef enum logic [1:0] {IDLE, INSTR, DATA, STOP} arb_state_t;
    function automatic logic [1:0] dev_sel(input logic [1:0] top);
        return top == 2'b00 ? SEL_FLASH : top == 2'b01 ? SEL_NONE : top;
    endfunction
endpackage

// File: rtl/qspi_addr_decode.sv
// qspi_addr_decode: maps address top bits to a chip select and flags illegal accesses
module qspi_addr_decode
    import qspi_pkg::*;
(
    input  logic [1:0] top,
    input  logic [1:0] len,
    input  logic       write,
    input  logic       stream,
    output logic [1:0] sel,
    output logic       ok
);
    always_comb begin
        sel = dev_sel(top);
        ok  = sel != SEL_NONE && (stream || (len != LEN_STREAM && !(write && sel == SEL_FLASH)));
    end
endmodule

// File: rtl/qspi_arbiter.sv
// qspi_arbiter: grants the shared QSPI controller to fetch or data; QSPI_ARB_STARVE_LIMIT_EN bounds fetch starvation
module qspi_arbiter
    import qspi_pkg::*;
#(
    parameter int ADDR_W       = 24,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] instr_addr,
    input  logic              instr_req,
    input  logic              instr_stop,
    output logic [15:0]       instr_data,
    output logic              instr_valid,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic              data_req,
    input  logic              data_write,
    input  logic [1:0]        data_len,
    input  logic [31:0]       data_wdata,
    output logic [31:0]       data_rdata,
    output logic              data_ack,
    output logic              data_err,
    output logic              ctrl_start,
    output logic              ctrl_stop,
    output logic [ADDR_W-1:0] ctrl_addr,
    output logic              ctrl_write,
    output logic [1:0]        ctrl_len,
    output logic [31:0]       ctrl_wdata,
    output logic [1:0]        ctrl_sel,
    input  logic              ctrl_busy,
    input  logic              ctrl_hw_valid,
    input  logic [31:0]       ctrl_rdata,
    input  logic              ctrl_done
);
    arb_state_t state;
    logic [1:0] d_sel, i_sel;
    logic d_ok, i_ok, data_seen, starve, protect, i_take, d_take, leave;
    qspi_addr_decode u_data_dec (
        .top(data_addr[ADDR_W-1 -: 2]), .len(data_len), .write(data_write),
        .stream(1'b0), .sel(d_sel), .ok(d_ok)
    );
    qspi_addr_decode u_instr_dec (
        .top(instr_addr[ADDR_W-1 -: 2]), .len(LEN_STREAM), .write(1'b0),
        .stream(1'b1), .sel(i_sel), .ok(i_ok)
    );
    // a request still high during its own ack/err cycle is the old access, not a new one
    assign data_seen   = data_req && !data_ack && !data_err;
    assign i_take      = instr_req && i_ok && (!data_seen || starve);
    assign d_take      = data_seen && !i_take;
    assign leave       = instr_stop || !instr_req || (data_req && !protect);
    assign instr_valid = state == INSTR && ctrl_hw_valid && !leave;
    assign instr_data  = state == INSTR ? ctrl_rdata[15:0] : 16'h0;
`ifdef QSPI_ARB_STARVE_LIMIT_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_cnt;
    logic guard;
    assign starve  = starve_cnt == CNT_W'(STARVE_LIMIT);
    assign protect = guard;
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            guard      <= 1'b0;
        end else if (state == IDLE && i_take) begin
            starve_cnt <= '0;
            guard      <= starve && data_seen;
        end else begin
            if (state == IDLE && d_take && d_ok && instr_req && !starve) starve_cnt <= starve_cnt + 1'b1;
            if (instr_valid) guard <= 1'b0;
        end
    end
`else
    assign starve  = 1'b0;
    assign protect = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ctrl_start <= 1'b0;
            ctrl_stop  <= 1'b0;
            ctrl_addr  <= '0;
            ctrl_write <= 1'b0;
            ctrl_len   <= LEN_1B;
            ctrl_wdata <= '0;
            ctrl_sel   <= SEL_NONE;
            data_rdata <= '0;
            data_ack   <= 1'b0;
            data_err   <= 1'b0;
        end else begin
            ctrl_start <= 1'b0;
            data_ack   <= 1'b0;
            data_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_take && d_ok) begin
                        ctrl_addr  <= data_addr;
                        ctrl_write <= data_write;
                        ctrl_len   <= data_len;
                        ctrl_wdata <= data_wdata;
                        ctrl_sel   <= d_sel;
                        ctrl_start <= 1'b1;
                        state      <= DATA;
                    end else if (d_take) begin
                        data_err <= 1'b1;
                    end else if (i_take) begin
                        ctrl_addr  <= instr_addr;
                        ctrl_write <= 1'b0;
                        ctrl_len   <= LEN_STREAM;
                        ctrl_sel   <= i_sel;
                        ctrl_start <= 1'b1;
                        state      <= INSTR;
                    end
                end
                INSTR: begin
                    if (leave) begin
                        ctrl_stop <= 1'b1;
                        state     <= STOP;
                    end
                end
                STOP: begin
                    if (!ctrl_busy) begin
                        ctrl_stop <= 1'b0;
                        ctrl_sel  <= SEL_NONE;
                        state     <= IDLE;
                    end
                end
                DATA: begin
                    if (ctrl_done) begin
                        data_rdata <= ctrl_rdata;
                        data_ack   <= 1'b1;
                        ctrl_sel   <= SEL_NONE;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
